// File: rtl/spi_responder_pkg.sv
// Shared constants and types for the 3-wire SPI register responder.
// Frame field positions mirror spi_param.h (SI_DataL / SO_DataL).
package spi_responder_pkg;

  localparam int unsigned SI_DataL  = 15;                    // frame MSB (R/W bit)
  localparam int unsigned SO_DataL  = 7;                     // data field MSB
  localparam int unsigned FRAME_W   = SI_DataL + 1;
  localparam int unsigned DATA_W    = SO_DataL + 1;
  localparam int unsigned ADDR_MSB  = SI_DataL - 1;
  localparam int unsigned ADDR_LSB  = SO_DataL + 1;
  localparam int unsigned ADDR_W    = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned HDR_BITS  = FRAME_W - DATA_W;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned REG_AW    = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned ADDR_ID     = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned REG_FIRST   = 2;
  localparam int unsigned REG_LAST    = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // True for addresses backed by a writable register.
  function automatic logic is_rw_reg(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(REG_FIRST)) && (a <= ADDR_W'(REG_LAST));
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulse detection on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Idle-high reset so an idle bus produces no edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_responder.sv
// 3-wire SPI responder: 16-bit R/W frames into a small register file,
// oversampled in the iCLK domain.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic              iSPI_CSN,
  input  logic              iSPI_SCLK,
  inout  wire               SPI_SDIO,
  output logic              oSDIO_OE,
  input  logic [7:0]        iSTATUS,
  output logic [7:0]        oCTRL,
  output logic              oWR_STB,
  output logic [REG_AW-1:0] oWR_ADDR,
  output logic [7:0]        oWR_DATA
);

  state_t state, next_state;

  logic sclk_rise_c, sclk_fall_c, csn_rise_c, csn_fall_c;
  logic [SYNC_STAGES-1:0] sdio_q;
  logic sdi_c;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-2:0] byte_q;
  logic [DATA_W-1:0] byte_nxt_c;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] hdr_addr_c;
  logic [DATA_W-1:0] rd_byte_c;
  logic [DATA_W-1:0] rd_shift_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  wr_req_t           wr_q;
  logic hdr_end_c, wr_end_c, shift_active_c;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (iCLK),
    .rst_n  (iRSTN),
    .d      (iSPI_SCLK),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn_sync (
    .clk    (iCLK),
    .rst_n  (iRSTN),
    .d      (iSPI_CSN),
    .rise_c (csn_rise_c),
    .fall_c (csn_fall_c)
  );

  // SDIO gets the same depth as SCLK so data lines up with the detected edge.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) sdio_q <= '1;
    else        sdio_q <= {sdio_q[SYNC_STAGES-2:0], SPI_SDIO};
  end

  assign sdi_c          = sdio_q[SYNC_STAGES-1];
  assign byte_nxt_c     = {byte_q, sdi_c};
  assign hdr_addr_c     = byte_nxt_c[ADDR_W-1:0];
  assign shift_active_c = (state == ST_ADDR) || (state == ST_WDATA) || (state == ST_RDATA);

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    hdr_end_c  = 1'b0;
    wr_end_c   = 1'b0;
    unique case (state)
      ST_IDLE:  if (csn_fall_c) next_state = ST_ADDR;
      ST_ADDR: begin
        if (sclk_rise_c && (cnt_q == CNT_W'(HDR_BITS - 1))) begin
          hdr_end_c  = 1'b1;
          next_state = byte_nxt_c[ADDR_W] ? ST_RDATA : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (sclk_rise_c && (cnt_q == CNT_W'(FRAME_W - 1))) begin
          wr_end_c   = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_RDATA: begin
        if (sclk_rise_c && (cnt_q == CNT_W'(FRAME_W - 1))) next_state = ST_DONE;
      end
      ST_DONE:  next_state = ST_DONE;
      default:  next_state = ST_IDLE;
    endcase
    // CSN release ends the frame from any state; mid-frame it discards everything.
    if (csn_rise_c) begin
      next_state = ST_IDLE;
      hdr_end_c  = 1'b0;
      wr_end_c   = 1'b0;
    end
  end

  always_comb begin
    rd_byte_c = '0;
    if (hdr_addr_c == ADDR_W'(ADDR_ID))          rd_byte_c = ID_VALUE;
    else if (hdr_addr_c == ADDR_W'(ADDR_STATUS)) rd_byte_c = iSTATUS;
    else if (is_rw_reg(hdr_addr_c))              rd_byte_c = regs_q[hdr_addr_c[REG_AW-1:0]];
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      cnt_q      <= '0;
      byte_q     <= '0;
      addr_q     <= '0;
      rd_shift_q <= '0;
      oSDIO_OE   <= 1'b0;
      oWR_STB    <= 1'b0;
      wr_q       <= '0;
    end else begin
      oWR_STB <= 1'b0;
      if ((state == ST_IDLE) && csn_fall_c) begin
        cnt_q <= '0;
      end else if (sclk_rise_c && shift_active_c) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        byte_q <= byte_nxt_c[DATA_W-2:0];
      end
      if (hdr_end_c) begin
        addr_q     <= hdr_addr_c;
        rd_shift_q <= rd_byte_c;
      end
      if (wr_end_c && is_rw_reg(addr_q)) begin
        oWR_STB   <= 1'b1;
        wr_q.addr <= addr_q[REG_AW-1:0];
        wr_q.data <= byte_nxt_c;
      end
      // First falling edge in RDATA exposes bit7; later ones advance the shifter.
      if (csn_rise_c) begin
        oSDIO_OE <= 1'b0;
      end else if (sclk_fall_c) begin
        if (state == ST_RDATA) begin
          if (!oSDIO_OE) oSDIO_OE <= 1'b1;
          else           rd_shift_q <= {rd_shift_q[DATA_W-2:0], 1'b0};
        end else if (state == ST_DONE) begin
          oSDIO_OE <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_end_c && is_rw_reg(addr_q)) begin
      regs_q[addr_q[REG_AW-1:0]] <= byte_nxt_c;
    end
  end

  assign SPI_SDIO = oSDIO_OE ? rd_shift_q[DATA_W-1] : 1'bz;
  assign oCTRL    = regs_q[REG_FIRST];
  assign oWR_ADDR = wr_q.addr;
  assign oWR_DATA = wr_q.data;

endmodule
